// File: rtl/otter_hazard_ctrl.sv
// otter_hazard_ctrl: load-use stall, redirect flush and memory-wait freeze sequencing for the 5-stage OTTER
module otter_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_valid,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [6:0] op;
  logic use_rs1, use_rs2, load_use, frz;
  assign op = id_instr[6:0];
  assign use_rs2 = op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  assign use_rs1 = use_rs2 || op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111;
  assign load_use = id_valid && ex_valid && ex_mem_read && ex_rd != 5'd0 &&
                    ((use_rs1 && id_instr[19:15] == ex_rd) || (use_rs2 && id_instr[24:20] == ex_rd));
  assign frz = state == S_ERR ? 1'b1 : state == S_WAIT ? ~mem_ack : mem_req & ~mem_ack;
  assign mem_err = state == S_ERR;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      wait_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      if ((frz || (!ex_redirect && load_use)) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (ex_redirect && !frz && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
  // MEM_REQ is deliberately ignored once waiting: the MEM stage holds it while frozen
  always_comb begin
    state_nxt = state;
    wait_nxt = wait_cnt;
    if (state == S_RUN) begin
      state_nxt = frz ? S_WAIT : S_RUN;
      wait_nxt = frz ? WW'(1) : '0;
    end else if (state == S_WAIT) begin
      state_nxt = mem_ack ? S_RUN : wait_cnt == WW'(MEM_TIMEOUT - 1) ? S_ERR : S_WAIT;
      wait_nxt = mem_ack ? '0 : wait_cnt == WW'(MEM_TIMEOUT - 1) ? wait_cnt : wait_cnt + 1'b1;
    end
  end
  always_comb begin
    pc_we = 1'b1;
    if_id_we = 1'b1;
    if_id_flush = 1'b0;
    id_ex_bubble = 1'b0;
    freeze = 1'b0;
    if (rst) begin
      pc_we = 1'b0;
      if_id_we = 1'b0;
      if_id_flush = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (frz) begin
      pc_we = 1'b0;
      if_id_we = 1'b0;
      freeze = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_we = 1'b0;
      if_id_we = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end
endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// tb_otter_hazard_ctrl: directed checks of stall, flush, freeze, timeout and counter saturation
module tb_otter_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] id_instr;
  logic id_valid, ex_mem_read, ex_valid, ex_redirect, mem_req, mem_ack;
  logic [4:0] ex_rd;
  logic pc_we, if_id_we, if_id_flush, id_ex_bubble, freeze, mem_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic pc_we4, if_id_we4, if_id_flush4, id_ex_bubble4, freeze4, mem_err4;
  logic [3:0] stall_cnt4, flush_cnt4;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  otter_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_valid(ex_valid), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .freeze(freeze),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  otter_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_valid(ex_valid), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_we(pc_we4), .if_id_we(if_id_we4),
    .if_id_flush(if_id_flush4), .id_ex_bubble(id_ex_bubble4), .freeze(freeze4),
    .mem_err(mem_err4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_id_ex(input logic [31:0] ins, input logic [4:0] rd, input logic ld);
    id_instr = ins;
    id_valid = 1'b1;
    ex_rd = rd;
    ex_mem_read = ld;
    ex_valid = 1'b1;
    #1;
  endtask
  initial begin
    rst = 1'b1; id_instr = '0; id_valid = 1'b0; ex_rd = '0; ex_mem_read = 1'b0;
    ex_valid = 1'b0; ex_redirect = 1'b0; mem_req = 1'b1; mem_ack = 1'b0;
    tick();
    chk("rst_pc_we", pc_we, 0);
    chk("rst_if_id_we", if_id_we, 0);
    chk("rst_flush", if_id_flush, 1);
    chk("rst_bubble", id_ex_bubble, 1);
    chk("rst_freeze", freeze, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    rst = 1'b0; mem_req = 1'b0;
    // T1: add x3,x1,x2 behind lw x1
    set_id_ex(32'h002081B3, 5'd1, 1'b1);
    chk("t1_pc_we", pc_we, 0);
    chk("t1_if_id_we", if_id_we, 0);
    chk("t1_bubble", id_ex_bubble, 1);
    chk("t1_flush", if_id_flush, 0);
    tick();
    ex_mem_read = 1'b0; #1;
    chk("t1_release_pc_we", pc_we, 1);
    chk("t1_release_bubble", id_ex_bubble, 0);
    chk("t1_stall_cnt", stall_cnt, 1);
    // T2: lui, I-type with rs2 field matching, lw x0, invalid ID
    set_id_ex(32'h000010B7, 5'd1, 1'b1);
    chk("t2_lui", pc_we, 1);
    set_id_ex(32'h00110293, 5'd1, 1'b1);
    chk("t2_addi_rs2field", pc_we, 1);
    set_id_ex(32'h00108293, 5'd1, 1'b1);
    chk("t2_addi_rs1_stall", pc_we, 0);
    set_id_ex(32'h000001B3, 5'd0, 1'b1);
    chk("t2_lw_x0", pc_we, 1);
    set_id_ex(32'h002081B3, 5'd2, 1'b1);
    chk("t2_rs2_stall", id_ex_bubble, 1);
    id_valid = 1'b0; #1;
    chk("t2_id_invalid", pc_we, 1);
    tick();
    chk("t2_stall_cnt", stall_cnt, 1);
    // T3: redirect overrides load-use
    set_id_ex(32'h002081B3, 5'd1, 1'b1);
    ex_redirect = 1'b1; #1;
    chk("t3_pc_we", pc_we, 1);
    chk("t3_if_id_we", if_id_we, 1);
    chk("t3_flush", if_id_flush, 1);
    chk("t3_bubble", id_ex_bubble, 1);
    tick();
    ex_redirect = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; #1;
    chk("t3_flush_cnt", flush_cnt, 1);
    chk("t3_stall_cnt", stall_cnt, 1);
    // T4: three wait states, redirect ignored while frozen, req dropped mid-wait
    for (int i = 0; i < 4; i++) begin
      mem_req = (i != 1);
      mem_ack = (i == 3);
      ex_redirect = (i < 3);
      #1;
      chk($sformatf("t4_freeze_%0d", i), freeze, (i < 3) ? 1 : 0);
      if (i < 3) chk($sformatf("t4_pc_we_%0d", i), pc_we, 0);
      if (i < 3) chk($sformatf("t4_flush_%0d", i), if_id_flush, 0);
      tick();
    end
    chk("t4_stall_cnt", stall_cnt, 4);
    chk("t4_flush_cnt", flush_cnt, 1);
    mem_req = 1'b1; mem_ack = 1'b1; ex_redirect = 1'b0; #1;
    chk("t4_zero_wait", freeze, 0);
    tick();
    mem_req = 1'b0; mem_ack = 1'b0; #1;
    chk("t4_after_zero_wait", freeze, 0);
    // T5: timeout after 16 frozen cycles
    mem_req = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("t5_no_err_at_15", mem_err, 0);
    chk("t5_freeze_at_15", freeze, 1);
    tick();
    chk("t5_err_at_16", mem_err, 1);
    mem_req = 1'b0; mem_ack = 1'b1; #1;
    chk("t5_err_freeze", freeze, 1);
    tick();
    chk("t5_err_sticky", mem_err, 1);
    chk("t5_stall_cnt", stall_cnt, 21);
    chk("t6_sat_stall4", {28'd0, stall_cnt4}, 32'hF);
    chk("t6_flush4", {28'd0, flush_cnt4}, 1);
    rst = 1'b1; tick();
    chk("t5_rst_freeze", freeze, 0);
    rst = 1'b0; mem_ack = 1'b0; #1;
    chk("t5_clr_err", mem_err, 0);
    chk("t5_clr_stall", stall_cnt, 0);
    chk("t5_clr_flush", flush_cnt, 0);
    chk("t5_run_pc_we", pc_we, 1);
    chk("t5_run_freeze", freeze, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
